// File: rtl/trng_pkg.sv
// Shared constants and types for the TRNG word collector and its FIFO.
package trng_pkg;

    localparam int TRNG_DATA_W     = 16;
    localparam int TRNG_FIFO_DEPTH = 4;
    localparam int TRNG_DISC_W     = 8;

    // Order in which serial bits land in the assembled word.
    typedef enum logic {
        TRNG_MSB_FIRST = 1'b0,
        TRNG_LSB_FIRST = 1'b1
    } trng_bit_order_e;

    // Width needed to hold an occupancy count of 0..depth.
    function automatic int trng_level_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/trng_word_fifo.sv
// Synchronous word FIFO with a registered level count; rdata reads 0 when empty.
module trng_word_fifo
    import trng_pkg::*;
#(
    parameter int DATA_W = TRNG_DATA_W,
    parameter int DEPTH  = TRNG_FIFO_DEPTH,
    localparam int LVL_W = trng_level_w(DEPTH)
) (
    input  logic              rng_clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              full,
    output logic              empty,
    output logic [LVL_W-1:0]  level
);

    localparam int             PTR_W    = $clog2(DEPTH);
    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              do_push;
    logic              do_pop;

    // A push into a full FIFO is legal only when the head leaves on the same edge.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    assign empty = (level == '0);
    assign full  = (level == LVL_FULL);
    assign rdata = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge rng_clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (!rst_n || clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)      level <= level + 1'b1;
            else if (!do_push && do_pop) level <= level - 1'b1;
        end
    end

    // NOTE: storage is not reset; the empty decode on rdata masks stale entries.
    always_ff @(posedge rng_clk) begin
        if (do_push && rst_n && !clr) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/trng_collector_fifo.sv
// Assembles serial balance-filter bits into words and queues them for CRNGT/EHR readers.
module trng_collector_fifo
    import trng_pkg::*;
#(
    parameter int DATA_W = TRNG_DATA_W,
    parameter int DEPTH  = TRNG_FIFO_DEPTH,
    parameter bit MSB_IN = 1'b1,
    parameter int DISC_W = TRNG_DISC_W
) (
    input  logic                           rng_clk,
    input  logic                           rst_n,
    input  logic                           rst_trng_logic,
    input  logic                           balance_filter_valid,
    input  logic                           balance_filter_data,
    input  logic                           collector_rd,
    output logic                           collector_valid,
    output logic [DATA_W-1:0]              collector_data,
    output logic                           collector_full,
    output logic [trng_level_w(DEPTH)-1:0] collector_level,
    output logic [DISC_W-1:0]              collector_discard_cnt
);

    localparam int                CNT_W    = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(DATA_W);
    localparam trng_bit_order_e   ORDER    = trng_bit_order_e'(MSB_IN);

    logic [DATA_W-1:0] shift_q, shift_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DISC_W-1:0] disc_q;
    logic              asm_full;
    logic              fifo_empty;
    logic              push, pop, accept, drop;

    assign asm_full = (cnt_q == CNT_FULL);
    assign pop      = collector_rd && !fifo_empty;
    assign push     = asm_full && (!collector_full || pop);
    assign accept   = balance_filter_valid && (!asm_full || push);
    assign drop     = balance_filter_valid && !accept;

    always_comb begin
        // NOTE: defaults first so no path leaves a variable unassigned (no latches).
        shift_d = shift_q;
        cnt_d   = cnt_q;
        if (push) cnt_d = '0;
        if (accept) begin
            if (ORDER == TRNG_LSB_FIRST) shift_d = {balance_filter_data, shift_q[DATA_W-1:1]};
            else                         shift_d = {shift_q[DATA_W-2:0], balance_filter_data};
            cnt_d = cnt_d + 1'b1;
        end
    end

    always_ff @(posedge rng_clk) begin
        if (!rst_n || rst_trng_logic) begin
            shift_q <= '0;
            cnt_q   <= '0;
            disc_q  <= '0;
        end else begin
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            if (drop && (disc_q != '1)) disc_q <= disc_q + 1'b1;
        end
    end

    trng_word_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .rng_clk (rng_clk),
        .rst_n   (rst_n),
        .clr     (rst_trng_logic),
        .push    (push),
        .pop     (pop),
        .wdata   (shift_q),
        .rdata   (collector_data),
        .full    (collector_full),
        .empty   (fifo_empty),
        .level   (collector_level)
    );

    assign collector_valid       = !fifo_empty;
    assign collector_discard_cnt = disc_q;

endmodule

// File: tb/tb_trng_collector_fifo.sv
// Directed and scoreboarded checks of trng_collector_fifo in three parameterisations.
module tb_trng_collector_fifo;
    import trng_pkg::*;

    localparam int DW = 16;
    localparam int DP = 4;

    logic rng_clk = 1'b0;
    always #5 rng_clk = ~rng_clk;

    logic rst_n, rst_trng_logic, bf_valid, bf_data, rd;

    logic        d_valid, d_full, l_valid, l_full, s_valid, s_full;
    logic [15:0] d_data, l_data, s_data;
    logic [2:0]  d_level, l_level, s_level;
    logic [7:0]  d_disc, l_disc;
    logic [3:0]  s_disc;

    int total = 0;
    int bad   = 0;

    // scoreboard state for the random phase
    logic [15:0] mq [$];
    logic [15:0] m_word;
    int          m_cnt, m_drop, popped, cycles, max_lvl;
    bit          m_pop, m_push, m_acc;
    logic [15:0] w5;
    logic [15:0] exp_head [5];
    int          exp_lvl  [5];

    trng_collector_fifo dut (
        .rng_clk(rng_clk), .rst_n(rst_n), .rst_trng_logic(rst_trng_logic),
        .balance_filter_valid(bf_valid), .balance_filter_data(bf_data),
        .collector_rd(rd), .collector_valid(d_valid), .collector_data(d_data),
        .collector_full(d_full), .collector_level(d_level), .collector_discard_cnt(d_disc)
    );

    trng_collector_fifo #(.MSB_IN(1'b0)) dut_lsb (
        .rng_clk(rng_clk), .rst_n(rst_n), .rst_trng_logic(rst_trng_logic),
        .balance_filter_valid(bf_valid), .balance_filter_data(bf_data),
        .collector_rd(rd), .collector_valid(l_valid), .collector_data(l_data),
        .collector_full(l_full), .collector_level(l_level), .collector_discard_cnt(l_disc)
    );

    trng_collector_fifo #(.DISC_W(4)) dut_d4 (
        .rng_clk(rng_clk), .rst_n(rst_n), .rst_trng_logic(rst_trng_logic),
        .balance_filter_valid(bf_valid), .balance_filter_data(bf_data),
        .collector_rd(rd), .collector_valid(s_valid), .collector_data(s_data),
        .collector_full(s_full), .collector_level(s_level), .collector_discard_cnt(s_disc)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge rng_clk);
        #1;
    endtask

    task automatic send_word(input logic [15:0] w);
        for (int i = 0; i < DW; i++) begin
            bf_valid = 1'b1;
            bf_data  = w[i];
            tick();
        end
        bf_valid = 1'b0;
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_valid"}, {31'd0, d_valid}, 32'd0);
        check({tag, "_data"},  {16'd0, d_data},  32'd0);
        check({tag, "_full"},  {31'd0, d_full},  32'd0);
        check({tag, "_level"}, {29'd0, d_level}, 32'd0);
        check({tag, "_disc"},  {24'd0, d_disc},  32'd0);
    endtask

    initial begin
        rst_n = 1'b0; rst_trng_logic = 1'b0; bf_valid = 1'b0; bf_data = 1'b0; rd = 1'b0;
        exp_head = '{16'h3333, 16'h4444, 16'h5555, 16'h6667, 16'h0000};
        exp_lvl  = '{4, 3, 2, 1, 0};

        // reset with bits toggling
        bf_valid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            bf_data = i[0];
            tick();
        end
        check_cleared("rst");
        check("rst_lsb_any", {27'd0, l_valid, l_full, l_level == 3'd0, l_disc == 8'd0, l_data == 16'd0}, 32'h7);
        check("rst_d4_any", {27'd0, s_valid, s_full, s_level == 3'd0, s_disc == 4'd0, s_data == 16'd0}, 32'h7);
        rst_n = 1'b1;

        // partial word then soft clear, then a clean word
        for (int i = 0; i < 9; i++) begin
            bf_valid = 1'b1;
            bf_data  = ~i[0];
            tick();
        end
        rst_trng_logic = 1'b1;
        tick();
        rst_trng_logic = 1'b0;
        send_word(16'h1234);
        tick();
        check("clr_level", {29'd0, d_level}, 32'd1);
        check("clr_data", {16'd0, d_data}, 32'h1234);
        check("clr_lsb_data", {16'd0, l_data}, 32'h2C48);
        check("clr_disc", {24'd0, d_disc}, 32'd0);
        rd = 1'b1;
        tick();
        rd = 1'b0;
        check("clr_one_word", {31'd0, d_valid}, 32'd0);
        check("clr_empty_data", {16'd0, d_data}, 32'd0);

        // bit order and push latency
        send_word(16'hA5C3);
        check("lat_not_yet", {29'd0, d_level}, 32'd0);
        tick();
        check("ord_msb_in", {16'd0, d_data}, 32'hA5C3);
        check("ord_level", {29'd0, d_level}, 32'd1);
        check("ord_lsb_in", {16'd0, l_data}, 32'hC3A5);
        check("ord_lsb_valid", {31'd0, l_valid}, 32'd1);
        rd = 1'b1;
        tick();
        rd = 1'b0;
        check("ord_drained", {29'd0, d_level}, 32'd0);

        // fill to full, fifth word held, then three dropped bits
        send_word(16'h1111);
        send_word(16'h2222);
        send_word(16'h3333);
        send_word(16'h4444);
        send_word(16'h5555);
        for (int i = 0; i < 3; i++) begin
            bf_valid = 1'b1;
            bf_data  = i[0];
            tick();
        end
        bf_valid = 1'b0;
        check("full_level", {29'd0, d_level}, 32'd4);
        check("full_flag", {31'd0, d_full}, 32'd1);
        check("full_head", {16'd0, d_data}, 32'h1111);
        check("full_disc", {24'd0, d_disc}, 32'd3);
        check("full_disc_d4", {28'd0, s_disc}, 32'd3);

        // pop while full: held word pushes, accepted bit starts next word
        w5 = 16'h6667;
        rd = 1'b1; bf_valid = 1'b1; bf_data = w5[0];
        tick();
        rd = 1'b0; bf_valid = 1'b0;
        check("pp_level", {29'd0, d_level}, 32'd4);
        check("pp_head", {16'd0, d_data}, 32'h2222);
        check("pp_disc", {24'd0, d_disc}, 32'd3);
        for (int i = 1; i < DW; i++) begin
            bf_valid = 1'b1;
            bf_data  = w5[i];
            tick();
        end
        bf_valid = 1'b0;
        check("pp_no_loss", {24'd0, d_disc}, 32'd3);
        for (int i = 0; i < 5; i++) begin
            rd = 1'b1;
            tick();
            check($sformatf("drain_head%0d", i), {16'd0, d_data}, {16'd0, exp_head[i]});
            check($sformatf("drain_level%0d", i), {29'd0, d_level}, exp_lvl[i]);
        end
        rd = 1'b0;

        // reads on empty FIFO
        rd = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        rd = 1'b0;
        check("under_level", {29'd0, d_level}, 32'd0);
        check("under_valid", {31'd0, d_valid}, 32'd0);

        // discard counter saturation
        for (int i = 0; i < 5; i++) send_word(16'hC0DE + 16'(i));
        for (int i = 0; i < 20; i++) begin
            bf_valid = 1'b1;
            bf_data  = i[0];
            tick();
        end
        check("sat_d4", {28'd0, s_disc}, 32'd15);
        check("sat_d8", {24'd0, d_disc}, 32'd23);
        check("sat_d4_level", {29'd0, s_level}, 32'd4);
        for (int i = 0; i < 5; i++) tick();
        bf_valid = 1'b0;
        check("sat_d4_hold", {28'd0, s_disc}, 32'd15);
        check("sat_d8_more", {24'd0, d_disc}, 32'd28);

        // soft clear while full and holding
        rst_trng_logic = 1'b1; bf_valid = 1'b1; rd = 1'b1;
        tick();
        rst_trng_logic = 1'b0; bf_valid = 1'b0; rd = 1'b0;
        check_cleared("clr_full");
        check("clr_full_d4", {28'd0, s_disc}, 32'd0);

        // random traffic against a scoreboard
        m_word = '0; m_cnt = 0; m_drop = 0; popped = 0; cycles = 0; max_lvl = 0;
        while (popped < 1000 && cycles < 60000) begin
            bf_valid = ($urandom_range(0, 9) < 7);
            bf_data  = 1'($urandom_range(0, 1));
            rd       = ($urandom_range(0, 1) == 1);
            m_pop    = rd && (mq.size() > 0);
            if (m_pop) begin
                check("rnd_head", {16'd0, d_data}, {16'd0, mq[0]});
                popped++;
                void'(mq.pop_front());
            end
            m_push = (m_cnt == DW) && ((mq.size() < DP) || m_pop);
            m_acc  = bf_valid && ((m_cnt < DW) || m_push);
            if (bf_valid && !m_acc) m_drop++;
            if (m_push) begin
                mq.push_back(m_word);
                m_cnt = 0;
            end
            if (m_acc) begin
                m_word = {bf_data, m_word[15:1]};
                m_cnt++;
            end
            tick();
            cycles++;
            if (int'(d_level) > max_lvl) max_lvl = int'(d_level);
        end
        bf_valid = 1'b0; rd = 1'b0;
        check("rnd_words", popped, 32'd1000);
        check("rnd_level_end", {29'd0, d_level}, mq.size());
        check("rnd_max_level", {31'd0, max_lvl <= DP}, 32'd1);
        check("rnd_disc", {24'd0, d_disc}, (m_drop > 255) ? 255 : m_drop);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
